// File: rtl/lock_in_demodulator_if.sv
// Sample-stream and demodulated X/Y bundle for lock_in_demodulator.
interface lock_in_demodulator_if #(
    parameter int NUM_BITS = 24,
    parameter int NUM_CH   = 2
);
    logic                       sample_valid_i;
    logic [NUM_BITS-1:0]        ref_i;
    logic [NUM_CH*NUM_BITS-1:0] sig_i;
    logic                       ready_o;
    logic [NUM_CH*NUM_BITS-1:0] x_o;
    logic [NUM_CH*NUM_BITS-1:0] y_o;
    logic                       valid_o;
    logic                       overrun_o;

    modport master (
        output sample_valid_i, ref_i, sig_i,
        input  ready_o, x_o, y_o, valid_o, overrun_o
    );

    modport slave (
        input  sample_valid_i, ref_i, sig_i,
        output ready_o, x_o, y_o, valid_o, overrun_o
    );
endinterface

// File: rtl/lock_in_demodulator.sv
// Time-multiplexed lock-in: shared Hilbert MAC, per-channel I/Q integrate-and-dump.
// Define LOCKIN_SAT_EN to saturate the output narrowing instead of wrapping.
module lock_in_demodulator #(
    parameter int NUM_BITS   = 24,
    parameter int NUM_CH     = 2,
    parameter int LOG2_DECIM = 4
) (
    input logic clk_i,
    input logic reset_ni,
    lock_in_demodulator_if.slave bus
);
    localparam int N    = NUM_BITS;
    localparam int TAPS = 23;
    localparam int MID  = 11;
    localparam int AW   = 2 * N + 6;
    localparam int IW   = N + 1 + LOG2_DECIM;
    localparam int DW   = LOG2_DECIM + 1;
    localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SH_L = (N >= 24) ? N - 24 : 0;
    localparam int SH_R = (N < 24) ? 24 - N : 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HILB = 2'd1;
    localparam logic [1:0] S_MIX  = 2'd2;
    localparam logic [1:0] S_DUMP = 2'd3;

    localparam logic [DW-1:0] DEC_LAST = DW'((1 << LOG2_DECIM) - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);
    localparam logic signed [AW-1:0] Q_MAX = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW-1:0] Q_MIN = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};
`ifdef LOCKIN_SAT_EN
    localparam logic signed [IW-1:0] O_MAX = {{(IW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [IW-1:0] O_MIN = {{(IW-N+1){1'b1}}, {(N-1){1'b0}}};
`endif

    typedef logic signed [N-1:0] smp_t;

    // Q1.23 taps, left-aligned to the sample width
    function automatic smp_t coeff(input logic [4:0] idx);
        longint c;
        case (idx)
            5'd2:    c = -19348;
            5'd4:    c = -121992;
            5'd6:    c = -442606;
            5'd8:    c = -1310247;
            5'd10:   c = -5164372;
            5'd12:   c = 5164372;
            5'd14:   c = 1310247;
            5'd16:   c = 442606;
            5'd18:   c = 121992;
            5'd20:   c = 19348;
            default: c = 0;
        endcase
        return N'((c <<< SH_L) >>> SH_R);
    endfunction

    function automatic logic [N-1:0] narrow(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] m;
        m = v >>> LOG2_DECIM;
`ifdef LOCKIN_SAT_EN
        if (m > O_MAX)      narrow = O_MAX[N-1:0];
        else if (m < O_MIN) narrow = O_MIN[N-1:0];
        else                narrow = m[N-1:0];
`else
        narrow = m[N-1:0];
`endif
    endfunction

    logic [1:0]           state;
    smp_t                 ref_line [TAPS];
    smp_t                 sig_line [NUM_CH][TAPS];
    logic signed [AW-1:0] acc;
    smp_t                 quad;
    logic [4:0]           cnt;
    logic [CW-1:0]        ch;
    logic [DW-1:0]        decim_cnt;
    logic signed [IW-1:0] ix [NUM_CH];
    logic signed [IW-1:0] iy [NUM_CH];
    logic [NUM_CH*N-1:0]  x_r;
    logic [NUM_CH*N-1:0]  y_r;
    logic                 valid_r;
    logic                 overrun_r;

    smp_t                  ref_d;
    smp_t                  sig_k;
    smp_t                  quad_sat;
    logic signed [2*N-1:0] prod_h, prod_x, prod_y;
    logic signed [2*N-1:0] sh_x, sh_y;
    logic signed [AW-1:0]  acc_next, acc_sh;
    logic signed [N:0]     px, py;

    always_comb begin
        ref_d    = ref_line[MID];
        sig_k    = sig_line[ch][MID];
        prod_h   = (2*N)'(ref_line[cnt]) * (2*N)'(coeff(cnt));
        acc_next = acc + AW'(prod_h);
        acc_sh   = acc_next >>> (N - 1);
        if (acc_sh > Q_MAX)      quad_sat = Q_MAX[N-1:0];
        else if (acc_sh < Q_MIN) quad_sat = Q_MIN[N-1:0];
        else                     quad_sat = acc_sh[N-1:0];
        prod_x = (2*N)'(ref_d) * (2*N)'(sig_k);
        prod_y = (2*N)'(quad) * (2*N)'(sig_k);
        sh_x   = prod_x >>> (N - 1);
        sh_y   = prod_y >>> (N - 1);
        px     = sh_x[N:0];
        py     = sh_y[N:0];
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state     <= S_IDLE;
            acc       <= '0;
            quad      <= '0;
            cnt       <= '0;
            ch        <= '0;
            decim_cnt <= '0;
            x_r       <= '0;
            y_r       <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
            for (int j = 0; j < TAPS; j++) ref_line[j] <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                ix[k] <= '0;
                iy[k] <= '0;
                for (int j = 0; j < TAPS; j++) sig_line[k][j] <= '0;
            end
        end else begin
            valid_r <= 1'b0;
            if (bus.sample_valid_i && state != S_IDLE) overrun_r <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.sample_valid_i) begin
                        ref_line[0] <= bus.ref_i;
                        for (int j = 1; j < TAPS; j++) ref_line[j] <= ref_line[j-1];
                        for (int k = 0; k < NUM_CH; k++) begin
                            sig_line[k][0] <= bus.sig_i[k*N +: N];
                            for (int j = 1; j < TAPS; j++)
                                sig_line[k][j] <= sig_line[k][j-1];
                        end
                        acc   <= '0;
                        cnt   <= 5'd22;
                        state <= S_HILB;
                    end
                end
                S_HILB: begin
                    acc <= acc_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        quad  <= quad_sat;
                        ch    <= '0;
                        state <= S_MIX;
                    end
                end
                S_MIX: begin
                    ix[ch] <= ix[ch] + IW'(px);
                    iy[ch] <= iy[ch] + IW'(py);
                    ch     <= ch + 1'b1;
                    if (ch == CH_LAST) begin
                        if (decim_cnt == DEC_LAST) begin
                            decim_cnt <= '0;
                            state     <= S_DUMP;
                        end else begin
                            decim_cnt <= decim_cnt + 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_DUMP: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        x_r[k*N +: N] <= narrow(ix[k]);
                        y_r[k*N +: N] <= narrow(iy[k]);
                        ix[k] <= '0;
                        iy[k] <= '0;
                    end
                    valid_r <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready_o   = (state == S_IDLE);
    assign bus.x_o       = x_r;
    assign bus.y_o       = y_r;
    assign bus.valid_o   = valid_r;
    assign bus.overrun_o = overrun_r;
endmodule

// File: doc/lock_in_demodulator.md
# lock_in_demodulator

Multi-channel, time-multiplexed lock-in demodulator. One reference channel and NUM_CH signal channels share one Hilbert quadrature generator and one sequenced MAC. Each channel is mixed against in-phase and quadrature reference, then decimated by integrate-and-dump. The block sits between the ADC sample stream and the phase/amplitude readout, and replaces the fixed single-channel tick-driven lock-in.

## Interface
- NUM_BITS, 24: sample and output width, signed Q1.(NUM_BITS-1).
- NUM_CH, 2: number of signal channels (1..8).
- LOG2_DECIM, 4: decimation factor is 2^LOG2_DECIM input samples per output (0..12).

- clk_i  in  1  system clock.
- reset_ni  in  1  synchronous, active-low reset.
- sample_valid_i  in  1  one-cycle strobe: ref_i/sig_i hold a new sample.
- ref_i  in  NUM_BITS  clean reference sample.
- sig_i  in  NUM_CH*NUM_BITS  signal samples; channel k at [k*NUM_BITS +: NUM_BITS].
- ready_o  out  1  high in IDLE only.
- x_o  out  NUM_CH*NUM_BITS  in-phase outputs, same packing as sig_i.
- y_o  out  NUM_CH*NUM_BITS  quadrature outputs.
- valid_o  out  1  one-cycle pulse: x_o/y_o updated.
- overrun_o  out  1  sticky: a sample was dropped.

## Operation
- Delay lines: one 23-entry shift register for ref and one per channel. Each shifts on an accepted sample, and new data enters at index 0.
- Delayed ref and delayed sig are taken from index 11, which is the Hilbert group delay.
- Hilbert coefficients are fixed, Q1.23, index 0..22: 0,0,-19348,0,-121992,0,-442606,0,-1310247,0,-5164372,0,5164372,0,1310247,0,442606,0,121992,0,19348,0,0. For NUM_BITS≠24, the coefficients are left-aligned, i.e. scaled by 2^(NUM_BITS-24).
- Each input sample runs through states IDLE → HILB → MIX, then DUMP or IDLE:
  - IDLE: ready_o=1. On sample_valid_i, latch and shift all delay lines, clear the Hilbert accumulator, load tap counter = 22, go to HILB.
  - HILB: 23 cycles. Each cycle: acc += ref_line[cnt]*coeff[cnt], cnt--. After cnt=0: quad = acc >>> (NUM_BITS-1), saturated to NUM_BITS. Go to MIX with channel counter = 0.
  - MIX: NUM_CH cycles, one per channel k:
    - px = ref_d*sig_d[k] >>> (NUM_BITS-1) and py = quad*sig_d[k] >>> (NUM_BITS-1), each NUM_BITS+1 bits.
    - ix[k] += px and iy[k] += py. Integrators are NUM_BITS+1+LOG2_DECIM bits and never overflow.
    - After the last channel, decim_cnt++. If decim_cnt wrapped to 0, go to DUMP; else go to IDLE.
  - DUMP: 1 cycle.
    - For every k: out = integrator >>> LOG2_DECIM (mean), narrowed to NUM_BITS (see Configuration).
    - Register the results into x_o/y_o, clear all integrators, pulse valid_o, go to IDLE.
- Drop rule: sample_valid_i while not IDLE drops that sample. No shift occurs, and overrun_o is set.
- overrun_o clears only on reset.
- Reset (reset_ni=0 at a clock edge, including mid-HILB/MIX/DUMP):
  - state=IDLE, with all delay lines, accumulators, integrators and decim_cnt cleared.
  - x_o=y_o=0, valid_o=0, overrun_o=0, ready_o=1 on the following cycle.
  - Any partial output is discarded.

## Timing
- Sample acceptance: sample_valid_i and ready_o both high at the same clock edge.
- Busy time per sample: 23 + NUM_CH cycles, plus 1 on dump cycles. ready_o returns high at cycle 24+NUM_CH (+1) after acceptance.
- Minimum sample spacing: 25+NUM_CH cycles. This is 27 at default, well within the 1000-cycle tick.
- Output latency: valid_o asserts 24+NUM_CH+1 cycles after acceptance of the 2^LOG2_DECIM-th sample of a block. x_o/y_o are valid in that same cycle and held until the next valid_o.
- Group delay: 11 samples. Outputs are fully settled once the first decimation block starts ≥22 samples after reset.
- sample_valid_i coinciding with the valid_o cycle is accepted, because the block is already IDLE.

## Configuration
- LOCKIN_SAT_EN defined: narrowing of the mean to NUM_BITS saturates to [-2^(NUM_BITS-1), 2^(NUM_BITS-1)-1].
- LOCKIN_SAT_EN undefined: narrowing keeps the low NUM_BITS bits, so overflow wraps.
- The only overflow source is (-FS)*(-FS) = +2^(NUM_BITS-1).
- The Hilbert quad saturation is always present.

## Test plan
- Reset: hold reset_ni=0 for 3 cycles mid-MIX.
  - Required: x_o=y_o=0, valid_o=0, overrun_o=0, ready_o=1 the next cycle.
  - Required: next outputs equal a fresh run from reset.
- DC, defaults with LOG2_DECIM=2: ref=sig0=4194304 for 40 samples.
  - Required: settled x0=2097152, y0=0 (±2 LSB).
  - Required: valid_o every 4th accepted sample, 27 cycles after acceptance.
- Quadrature at fs/4: ref = 0,4194304,0,-4194304 repeated.
  - sig0 = ref: settled x0=1048576, |y0|≤1% of 1048576.
  - sig1 = ref delayed one sample: |x1|≤1%, |y1|=1048576±1%.
- Full-scale: ref=sig0=-8388608, LOG2_DECIM=0.
  - Required with LOCKIN_SAT_EN: x0=8388607.
  - Required without LOCKIN_SAT_EN: x0=-8388608.
- Overrun: pulse sample_valid_i at cycles 0 and 10.
  - Required: second sample dropped, delay lines shift once, overrun_o=1 from cycle 11 until reset.
- Channel independence, NUM_CH=4: sig1=-sig0, sig2=0, sig3=sig0, DC as above.
  - Required: x1=-x0, x2=0, x3=x0.
